// File: rtl/alu_pkg.sv
// Shared ALU definitions: FSM states, datapath widths and the flag bundle.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_pkg;

    localparam int XLEN    = 32;
    localparam int SLICE_W = 8;
    localparam int N_STEPS = XLEN / SLICE_W;
    localparam int K_W     = $clog2(N_STEPS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic of;
        logic sf;
        logic cf;
        logic zf;
    } flags_t;

endpackage

// File: rtl/add8_slice.sv
// Combinational 8-bit carry-lookahead adder slice.
// Latency: 0 cycles (pure combinational).
// Backpressure: none, no handshake.
//
// Ports: a, b (operand bytes), cin (carry in) -> s (sum byte), cout (carry out).
module add8_slice
    import alu_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] s,
    output logic               cout
);

    logic [SLICE_W-1:0] g;
    logic [SLICE_W-1:0] p;
    logic [SLICE_W:0]   c;

    assign g = a & b;
    assign p = a ^ b;

    // Each carry is formed directly from the generate/propagate terms of all
    // lower bits and cin, so no carry depends on another computed carry.
    always_comb begin
        logic prod;
        c    = '0;
        prod = 1'b0;
        c[0] = cin;
        for (int i = 0; i < SLICE_W; i++) begin
            prod = cin;
            for (int j = 0; j <= i; j++) begin
                prod = prod & p[j];
            end
            c[i+1] = prod;
            for (int j = 0; j <= i; j++) begin
                prod = g[j];
                for (int m = j + 1; m <= i; m++) begin
                    prod = prod & p[m];
                end
                c[i+1] = c[i+1] | prod;
            end
        end
    end

    assign s    = p ^ c[SLICE_W-1:0];
    assign cout = c[SLICE_W];

endmodule

// File: rtl/adder32_seq.sv
// Multi-cycle 32-bit add/subtract using one shared 8-bit slice, low byte first.
// Latency: 4 cycles from acceptance to out_valid; 1 op per 6 cycles at best.
// Backpressure: result and flags held in DONE until out_ready; in_ready=0 while busy.
//
// Ports: clk, rst (async active-high); in_valid/in_ready with x, y, sub (0 add, 1 sub);
//        flush (sync abort to IDLE); out_valid/out_ready with f and of/sf/cf/zf flags.
// Build option: define ADDER32_SEQ_FLAGS_EN to build the flag logic; otherwise the
//               flag outputs are tied to 0 and the zero accumulator is omitted.
module adder32_seq
    import alu_pkg::*;
#(
    parameter int W_SLICE = SLICE_W
)
(
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] x,
    input  logic [XLEN-1:0] y,
    input  logic            sub,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] f,
    output logic            of,
    output logic            sf,
    output logic            cf,
    output logic            zf
);

    state_t             state;
    logic [K_W-1:0]     k;
    logic               carry;
    logic [XLEN-1:0]    xr;
    logic [XLEN-1:0]    ytr;

    logic [W_SLICE-1:0] a_byte;
    logic [W_SLICE-1:0] b_byte;
    logic [W_SLICE-1:0] s_byte;
    logic               cout;
    logic [K_W+2:0]     lsb;
    logic               last_step;
    logic               step;

    // Bit offset of the byte being processed this cycle.
    assign lsb       = {k, 3'b000};
    assign a_byte    = xr[lsb +: W_SLICE];
    assign b_byte    = ytr[lsb +: W_SLICE];
    assign last_step = (k == K_W'(N_STEPS - 1));
    assign step      = (state == RUN) && !flush;

    add8_slice u_slice (
        .a    (a_byte),
        .b    (b_byte),
        .cin  (carry),
        .s    (s_byte),
        .cout (cout)
    );

    // Handshake outputs decode registered state only.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            k     <= '0;
            carry <= 1'b0;
            xr    <= '0;
            ytr   <= '0;
            f     <= '0;
        end else if (flush) begin
            // Abort wins over every transition; f keeps whatever it held.
            state <= IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        state <= RUN;
                        xr    <= x;
                        // Subtract as x + ~y + 1: the +1 enters as the initial carry.
                        ytr   <= sub ? ~y : y;
                        carry <= sub;
                        k     <= '0;
                    end
                end
                RUN: begin
                    f[lsb +: W_SLICE] <= s_byte;
                    carry             <= cout;
                    k                 <= k + 1'b1;
                    if (last_step) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ADDER32_SEQ_FLAGS_EN
    flags_t flg;
    logic   zacc;
    logic   subr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flg  <= '0;
            zacc <= 1'b0;
            subr <= 1'b0;
        end else if (state == IDLE && in_valid && !flush) begin
            zacc <= 1'b1;
            subr <= sub;
        end else if (step) begin
            zacc <= zacc & (s_byte == '0);
            if (last_step) begin
                // The top byte is only now available, so build flags from it
                // directly rather than from f, which updates on this same edge.
                flg.sf <= s_byte[W_SLICE-1];
                flg.zf <= zacc & (s_byte == '0);
                // Inverting the carry turns it into a borrow for subtract.
                flg.cf <= cout ^ subr;
                flg.of <= (~xr[XLEN-1] & ~ytr[XLEN-1] &  s_byte[W_SLICE-1]) |
                          ( xr[XLEN-1] &  ytr[XLEN-1] & ~s_byte[W_SLICE-1]);
            end
        end
    end

    assign of = flg.of;
    assign sf = flg.sf;
    assign cf = flg.cf;
    assign zf = flg.zf;
`else
    assign of = 1'b0;
    assign sf = 1'b0;
    assign cf = 1'b0;
    assign zf = 1'b0;
`endif

endmodule

// File: tb/tb_adder32_seq.sv
module tb_adder32_seq;

`ifdef ADDER32_SEQ_FLAGS_EN
    localparam bit FLAGS_EN = 1'b1;
`else
    localparam bit FLAGS_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] x;
    logic [31:0] y;
    logic        sub;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] f;
    logic        of, sf, cf, zf;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [31:0] f;
        logic [3:0]  fl;   // {of, sf, cf, zf}
    } exp_t;

    exp_t sb[$];

    adder32_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .sub       (sub),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .f         (f),
        .of        (of),
        .sf        (sf),
        .cf        (cf),
        .zf        (zf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Reference: plain 33-bit arithmetic, flags from operand/result signs.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic [32:0] r;
        logic        o;
        exp_t        e;
        if (s) begin
            r = {1'b0, a} - {1'b0, b};
            o = (a[31] != b[31]) && (r[31] != a[31]);
        end else begin
            r = {1'b0, a} + {1'b0, b};
            o = (a[31] == b[31]) && (r[31] != a[31]);
        end
        e.f  = r[31:0];
        e.fl = FLAGS_EN ? {o, r[31], r[32], (r[31:0] == 32'd0)} : 4'b0000;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op, wait for the result, hold it for 'hold' cycles, then drain.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input int hold, output logic [31:0] fo, output logic [3:0] flo);
        int   n;
        exp_t e;
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        check("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        x = a;
        y = b;
        sub = s;
        sb.push_back(model(a, b, s));
        tick();                                   // acceptance edge E0
        in_valid = 1'b0;
        check("in_ready_busy", 32'(in_ready), 32'd0);
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        check("latency", 32'(n), 32'd4);
        check("sb_nonempty", 32'(sb.size()), 32'd1);
        e = (sb.size() > 0) ? sb.pop_front() : '0;
        check("result_f", f, e.f);
        check("result_flags", {28'd0, of, sf, cf, zf}, {28'd0, e.fl});
        fo  = f;
        flo = {of, sf, cf, zf};
        for (int i = 0; i < hold; i++) begin
            // Operands offered while busy must be ignored.
            in_valid = 1'b1;
            x = $urandom;
            y = $urandom;
            tick();
            check("hold_f", f, e.f);
            check("hold_flags", {28'd0, of, sf, cf, zf}, {28'd0, e.fl});
            check("hold_in_ready", 32'(in_ready), 32'd0);
            check("hold_out_valid", 32'(out_valid), 32'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();                                   // completion handshake
        out_ready = 1'b0;
        check("drain_out_valid", 32'(out_valid), 32'd0);
        check("drain_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] rf;
        logic [3:0]  rfl;

        rst = 1'b1;
        in_valid = 1'b0;
        x = '0;
        y = '0;
        sub = 1'b0;
        flush = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_f", f, 32'd0);
        check("rst_flags", {28'd0, of, sf, cf, zf}, 32'd0);
        rst = 1'b0;
        tick();

        // Signed overflow on add.
        run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 0, rf, rfl);
        check("ovf_f", rf, 32'h8000_0000);
        check("ovf_flags", {28'd0, rfl}, FLAGS_EN ? 32'b1100 : 32'd0);

        // Carry through all four bytes.
        run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0, rf, rfl);
        check("carry_f", rf, 32'h0000_0000);
        check("carry_flags", {28'd0, rfl}, FLAGS_EN ? 32'b0011 : 32'd0);

        // Subtract equal values, then borrow.
        run_op(32'h0000_0005, 32'h0000_0005, 1'b1, 0, rf, rfl);
        check("sub_eq_f", rf, 32'd0);
        check("sub_eq_flags", {28'd0, rfl}, FLAGS_EN ? 32'b0001 : 32'd0);
        run_op(32'h0000_0000, 32'h0000_0001, 1'b1, 0, rf, rfl);
        check("borrow_f", rf, 32'hFFFF_FFFF);
        check("borrow_flags", {28'd0, rfl}, FLAGS_EN ? 32'b0110 : 32'd0);

        // Backpressure for 10 cycles, then an immediate follow-on op.
        run_op(32'h1234_5678, 32'h1111_1111, 1'b0, 10, rf, rfl);
        check("bp_f", rf, 32'h2345_6789);
        run_op(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1, 1, rf, rfl);

        // Reset at step k=2: immediate return to IDLE, result cleared.
        in_valid = 1'b1;
        x = 32'hAAAA_AAAA;
        y = 32'h5555_5555;
        sub = 1'b0;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("arst_in_ready", 32'(in_ready), 32'd1);
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_f", f, 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // Flush at step k=1: IDLE on the next edge, no result ever appears.
        in_valid = 1'b1;
        x = 32'h0F0F_0F0F;
        y = 32'h0101_0101;
        sub = 1'b0;
        tick();
        in_valid = 1'b0;
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 6; i++) begin
            check("flush_no_valid", 32'(out_valid), 32'd0);
            tick();
        end

        // Flush together with in_valid in IDLE: nothing accepted.
        flush = 1'b1;
        in_valid = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush_wins_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("flush_wins_no_valid", 32'(out_valid), 32'd0);
        end

        // Signed overflow on subtract after the aborts.
        run_op(32'h8000_0000, 32'h0000_0001, 1'b1, 0, rf, rfl);
        check("sub_ovf_f", rf, 32'h7FFF_FFFF);
        check("sub_ovf_of", 32'(rfl[3]), FLAGS_EN ? 32'd1 : 32'd0);
        check("sub_ovf_cf", 32'(rfl[1]), 32'd0);

        // A few random ops against the model.
        for (int i = 0; i < 8; i++) begin
            run_op($urandom, $urandom, 1'($urandom_range(0, 1)), i % 3, rf, rfl);
        end

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global timeout guard.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish (errors=%0d checks=%0d)", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
